// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {instr, pc}
// with valid/ready on both sides and RV32I field/immediate decode of the head.
module ir_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [6:0]                 opcode,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [31:0]                i_imm,
  output logic [31:0]                s_imm,
  output logic [31:0]                b_imm,
  output logic [31:0]                u_imm,
  output logic [31:0]                j_imm
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  logic             clear;

  // Handshake depends only on the count register; no pass-through when full.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != CNT_W'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign clear     = rst || flush;

  // Entry storage; contents are not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      instr_mem[tail] <= in_instr;
      pc_mem[tail]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents a NOP so downstream decode sees benign fields.
  assign out_instr = out_valid ? instr_mem[head] : NOP;
  assign out_pc    = out_valid ? pc_mem[head]    : 32'h0;

  assign opcode = out_instr[6:0];
  assign rd     = out_instr[11:7];
  assign funct3 = out_instr[14:12];
  assign rs1    = out_instr[19:15];
  assign rs2    = out_instr[24:20];
  assign funct7 = out_instr[31:25];

  assign i_imm = {{21{out_instr[31]}}, out_instr[30:20]};
  assign s_imm = {{21{out_instr[31]}}, out_instr[30:25], out_instr[11:7]};
  assign b_imm = {{20{out_instr[31]}}, out_instr[7], out_instr[30:25],
                  out_instr[11:8], 1'b0};
  assign u_imm = {out_instr[31:12], 12'h000};
  assign j_imm = {{12{out_instr[31]}}, out_instr[19:12], out_instr[20],
                  out_instr[30:21], 1'b0};

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue (DEPTH=4) with hand-computed expectations.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]  count;
  logic [2:0]  funct3;
  logic [6:0]  funct7, opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  int checks = 0;
  int errors = 0;

  ir_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count), .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0; in_instr = 32'hx; in_pc = 32'hx;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".count"},     32'(count),     32'd0);
    check({tag, ".out_instr"}, out_instr,      32'h0000_0013);
    check({tag, ".opcode"},    32'(opcode),    32'h13);
    check({tag, ".rd"},        32'(rd),        32'd0);
    check({tag, ".i_imm"},     i_imm,          32'd0);
    check({tag, ".out_pc"},    out_pc,         32'd0);
  endtask

  logic [31:0] w [4];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    step(); step();
    rst = 1'b0;
    step();
    check_empty("reset");

    // Single addi x1, x0, 5
    push_one(32'h0050_0093, 32'h100);
    check("addi.out_valid", 32'(out_valid), 32'd1);
    check("addi.count",     32'(count),     32'd1);
    check("addi.rd",        32'(rd),        32'd1);
    check("addi.rs1",       32'(rs1),       32'd0);
    check("addi.funct3",    32'(funct3),    32'd0);
    check("addi.i_imm",     i_imm,          32'd5);
    check("addi.out_pc",    out_pc,         32'h100);
    pop_one();
    check_empty("addi_pop");

    // Fill to DEPTH
    for (int k = 0; k < 4; k++) begin
      w[k] = 32'h1000_0000 + 32'(k * 32'h111);
      push_one(w[k], 32'h200 + 32'(4 * k));
      check($sformatf("fill%0d.count", k), 32'(count), 32'(k + 1));
    end
    check("full.in_ready", 32'(in_ready), 32'd0);
    push_one(32'hDEAD_BEEF, 32'h999);
    check("full_drop.count", 32'(count), 32'd4);
    check("full_drop.head",  out_instr,  w[0]);

    // Full with simultaneous pop: push still refused
    in_valid = 1'b1; in_instr = 32'hBAD0_0000; in_pc = 32'h998; out_ready = 1'b1;
    #1;
    check("full_pop.in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pop.count", 32'(count), 32'd3);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("drain%0d.instr", k), out_instr, w[k]);
      check($sformatf("drain%0d.pc", k),    out_pc,    32'h200 + 32'(4 * k));
      pop_one();
    end
    check_empty("drained");

    // Steady-state push/pop across pointer wrap
    push_one(32'h0000_A000, 32'h3000);
    push_one(32'h0000_A001, 32'h3004);
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_instr = 32'h0000_A000 + 32'(j + 2);
      in_pc = 32'h3000 + 32'(4 * (j + 2)); out_ready = 1'b1;
      check($sformatf("wrap%0d.head", j), out_instr, 32'h0000_A000 + 32'(j));
      check($sformatf("wrap%0d.pc", j),   out_pc,    32'h3000 + 32'(4 * j));
      step();
      check($sformatf("wrap%0d.count", j), 32'(count), 32'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_tail0", out_instr, 32'h0000_A00A);
    pop_one();
    check("wrap_tail1", out_instr, 32'h0000_A00B);
    pop_one();
    check("wrap_end.count", 32'(count), 32'd0);

    // Immediate sign extension
    push_one(32'hFE00_0FA3, 32'h400);
    check("sw.s_imm", s_imm, 32'hFFFF_FFFF);
    check("sw.opcode", 32'(opcode), 32'h23);
    pop_one();
    push_one(32'h8000_006F, 32'h404);
    check("jal.j_imm", j_imm, 32'hFFF0_0000);
    pop_one();
    push_one(32'h8000_0063, 32'h408);
    check("beq.b_imm", b_imm, 32'hFFFF_F000);
    pop_one();
    push_one(32'hFFFF_F037, 32'h40C);
    check("lui.u_imm", u_imm, 32'hFFFF_F000);
    check("lui.rd", 32'(rd), 32'd0);
    pop_one();

    // Flush at count=3 with push and pop requested
    push_one(32'h0000_B000, 32'h500);
    push_one(32'h0000_B001, 32'h504);
    push_one(32'h0000_B002, 32'h508);
    check("pre_flush.count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_B0FF; in_pc = 32'h5FC; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_empty("flush_empty");
    push_one(32'h0000_C000, 32'h600);
    check("post_flush.count", 32'(count), 32'd1);
    check("post_flush.head",  out_instr,  32'h0000_C000);
    check("post_flush.pc",    out_pc,     32'h600);
    pop_one();

    // Reset mid-stream with push active
    push_one(32'h0000_D000, 32'h700);
    push_one(32'h0000_D001, 32'h704);
    check("pre_rst.count", 32'(count), 32'd2);
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_D002; in_pc = 32'h708;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_empty("mid_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
